// File: rtl/bus_ram_slave_pkg.sv
// Shared types for the bus RAM slave: the RV32 word type and the slave FSM state encoding.

package RV32Consts;

  typedef logic [31:0] IntReg;

endpackage

package BusRamPkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE
  } bus_state_e;

  // Larger of the two latencies; sizes the shared countdown counter.
  function automatic int unsigned max_lat(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bus_ram_slave_if.sv
// Write and read request channels for the bus RAM slave.

interface WriteIF;
  import RV32Consts::*;

  logic       valid;
  IntReg      addr;
  logic [3:0] strb;
  IntReg      data;
  logic       done;

  modport Slave  (input  valid, addr, strb, data, output done);
  modport Master (output valid, addr, strb, data, input  done);
endinterface

interface ReadIF;
  import RV32Consts::*;

  logic  avalid;
  IntReg addr;
  IntReg data;
  logic  valid;

  modport Slave  (input  avalid, addr, output data, valid);
  modport Master (output avalid, addr, input  data, valid);
endinterface

// File: rtl/bus_ram_slave_byte_enable_ram.sv
// Word-organised RAM with per-byte write enables, synchronous write and combinational read.
// Contents are deliberately never reset.

module byte_enable_ram
  import RV32Consts::*;
#(
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clk,
  input  logic [3:0]               we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  IntReg                    wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output IntReg                    rdata
);

  IntReg mem [DEPTH];

  // Byte-lane write on the rising edge; lanes with a clear enable keep their old contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bus_ram_slave.sv
// Single-outstanding bus RAM slave with fixed read/write latencies, write-before-read ordering
// for simultaneous requests, and sticky out-of-range / protocol error flags.

module bus_ram_slave
  import BusRamPkg::*;
  import RV32Consts::*;
#(
  parameter int unsigned DEPTH         = 1024,
  parameter int unsigned READ_LATENCY  = 1,
  parameter int unsigned WRITE_LATENCY = 1
) (
  input  logic  clk,
  input  logic  rst_n,
  WriteIF.Slave w_bus,
  ReadIF.Slave  r_bus,
  output logic  oor_err,
  output logic  proto_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(max_lat(READ_LATENCY, WRITE_LATENCY)) + 1;
  localparam logic [CW-1:0] WrLoad = CW'(WRITE_LATENCY - 1);
  localparam logic [CW-1:0] RdLoad = CW'(READ_LATENCY - 1);

  bus_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic          pend_rd_q;
  logic          oor_err_q;
  logic          proto_err_q;

  logic [AW-1:0] w_idx_q;
  logic [3:0]    w_strb_q;
  IntReg         w_data_q;
  logic          w_oor_q;
  logic [AW-1:0] r_idx_q;
  logic          r_oor_q;

  logic          accept;
  logic          w_oor_in;
  logic          r_oor_in;
  logic          wr_fire;
  logic          rd_fire;
  logic [3:0]    ram_we;
  IntReg         ram_rdata;

  // Byte offset bits carry no meaning for a word-addressed RAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{w_bus.addr[1:0], r_bus.addr[1:0]};

  assign accept   = rst_n && (state_q == IDLE);
  assign w_oor_in = |w_bus.addr[31:AW+2];
  assign r_oor_in = |r_bus.addr[31:AW+2];

  // Completion strobes are gated by rst_n so a reset in the completion cycle suppresses them.
  assign wr_fire = rst_n && (state_q == WRITE) && (cnt_q == '0);
  assign rd_fire = rst_n && (state_q == READ) && (cnt_q == '0);

  assign ram_we      = (wr_fire && !w_oor_q) ? w_strb_q : 4'b0000;
  assign w_bus.done  = wr_fire;
  assign r_bus.valid = rd_fire;
  assign r_bus.data  = (rd_fire && !r_oor_q) ? ram_rdata : '0;
  assign oor_err     = oor_err_q;
  assign proto_err   = proto_err_q;

  // Capture request fields only when the slave is idle and the request is accepted.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (w_bus.valid) begin
        w_idx_q  <= w_bus.addr[AW+1:2];
        w_strb_q <= w_bus.strb;
        w_data_q <= w_bus.data;
        w_oor_q  <= w_oor_in;
      end
      if (r_bus.avalid) begin
        r_idx_q <= r_bus.addr[AW+1:2];
        r_oor_q <= r_oor_in;
      end
    end
  end

  // Control FSM: accept in IDLE, count down latency, chain a pending read after a write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pend_rd_q   <= 1'b0;
      oor_err_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (w_bus.valid) begin
            state_q   <= WRITE;
            cnt_q     <= WrLoad;
            pend_rd_q <= r_bus.avalid;
          end else if (r_bus.avalid) begin
            state_q <= READ;
            cnt_q   <= RdLoad;
          end
        end
        WRITE: begin
          if (w_bus.valid || r_bus.avalid) begin
            proto_err_q <= 1'b1;
          end
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            if (w_oor_q) begin
              oor_err_q <= 1'b1;
            end
            if (pend_rd_q) begin
              state_q   <= READ;
              cnt_q     <= RdLoad;
              pend_rd_q <= 1'b0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        READ: begin
          if (w_bus.valid || r_bus.avalid) begin
            proto_err_q <= 1'b1;
          end
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            if (r_oor_q) begin
              oor_err_q <= 1'b1;
            end
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  byte_enable_ram #(
    .DEPTH(DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(w_idx_q),
    .wdata(w_data_q),
    .raddr(r_idx_q),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_bus_ram_slave.sv
// Directed bench for bus_ram_slave: one instance at latency 1/1, one at read 3 / write 2.
// Read expectations come from a byte-lane memory model and are queued at issue, popped on valid.

module tb_bus_ram_slave;
  import BusRamPkg::*;
  import RV32Consts::*;

  logic clk = 1'b0;
  logic rst_n;
  logic oor1, proto1, oor3, proto3;

  WriteIF w1 ();
  ReadIF  r1 ();
  WriteIF w3 ();
  ReadIF  r3 ();

  bus_ram_slave #(
    .DEPTH        (1024),
    .READ_LATENCY (1),
    .WRITE_LATENCY(1)
  ) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .w_bus    (w1),
    .r_bus    (r1),
    .oor_err  (oor1),
    .proto_err(proto1)
  );

  bus_ram_slave #(
    .DEPTH        (1024),
    .READ_LATENCY (3),
    .WRITE_LATENCY(2)
  ) dut3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .w_bus    (w3),
    .r_bus    (r3),
    .oor_err  (oor3),
    .proto_err(proto3)
  );

  always #5 clk = ~clk;

  int    n_tests = 0;
  int    n_fail  = 0;
  IntReg exp_q[$];
  IntReg mdl1[int unsigned];
  IntReg mdl3[int unsigned];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input logic wv, input IntReg wa, input logic [3:0] ws,
                       input IntReg wd, input logic rv, input IntReg ra);
    if (d == 1) begin
      w1.valid = wv; w1.addr = wa; w1.strb = ws; w1.data = wd;
      r1.avalid = rv; r1.addr = ra;
    end else begin
      w3.valid = wv; w3.addr = wa; w3.strb = ws; w3.data = wd;
      r3.avalid = rv; r3.addr = ra;
    end
  endtask

  function automatic logic sdone(input int d);
    return (d == 1) ? w1.done : w3.done;
  endfunction

  function automatic logic svalid(input int d);
    return (d == 1) ? r1.valid : r3.valid;
  endfunction

  function automatic IntReg sdata(input int d);
    return (d == 1) ? r1.data : r3.data;
  endfunction

  function automatic IntReg mrd(input int d, input IntReg a);
    int unsigned idx = 32'(a[11:2]);
    if (a >= 32'h1000) return '0;
    if (d == 1) return mdl1.exists(idx) ? mdl1[idx] : 'x;
    return mdl3.exists(idx) ? mdl3[idx] : 'x;
  endfunction

  task automatic mwr(input int d, input IntReg a, input logic [3:0] s, input IntReg wd);
    int unsigned idx = 32'(a[11:2]);
    IntReg w;
    if (a >= 32'h1000) return;
    w = mrd(d, a);
    for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = wd[8*i +: 8];
    if (d == 1) mdl1[idx] = w; else mdl3[idx] = w;
  endtask

  // One request (write, read or both) followed by a fixed 12-cycle observation window.
  // inj_k > 0 injects an extra avalid pulse in that cycle after acceptance.
  task automatic xact(input string tag, input int d,
                      input logic wv, input IntReg wa, input logic [3:0] ws, input IntReg wd,
                      input logic rv, input IntReg ra, input int wlat, input int rlat,
                      input int inj_k, input IntReg inj_a);
    int   wl = 0, rl = 0, nd = 0, nv = 0;
    logic idle_bad = 1'b0;
    if (wv) mwr(d, wa, ws, wd);
    if (rv) exp_q.push_back(mrd(d, ra));
    @(negedge clk);
    drive(d, wv, wa, ws, wd, rv, ra);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (sdone(d)) begin
        nd++;
        if (wl == 0) wl = k;
      end
      if (svalid(d)) begin
        nv++;
        if (rl == 0) rl = k;
        if (exp_q.size() > 0) chk({tag, " data"}, sdata(d), exp_q.pop_front());
      end else if (sdata(d) !== '0) begin
        idle_bad = 1'b1;
      end
      if (k == inj_k) drive(d, 1'b0, '0, 4'h0, '0, 1'b1, inj_a);
      else drive(d, 1'b0, '0, 4'h0, '0, 1'b0, '0);
    end
    chk({tag, " done count"}, 32'(nd), wv ? 32'd1 : 32'd0);
    if (wv) chk({tag, " done latency"}, 32'(wl), 32'(wlat));
    chk({tag, " valid count"}, 32'(nv), rv ? 32'd1 : 32'd0);
    if (rv) chk({tag, " valid latency"}, 32'(rl), 32'(rlat));
    chk({tag, " idle data zero"}, {31'd0, idle_bad}, 32'd0);
    if (rv && nv == 0 && exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1, 1'b0, '0, 4'h0, '0, 1'b0, '0);
    drive(3, 1'b0, '0, 4'h0, '0, 1'b0, '0);
    repeat (3) @(negedge clk);
    chk("rst done1", {31'd0, w1.done}, 32'd0);
    chk("rst valid1", {31'd0, r1.valid}, 32'd0);
    chk("rst data1", r1.data, 32'd0);
    chk("rst flags1", {30'd0, oor1, proto1}, 32'd0);
    chk("rst state1", {30'd0, dut1.state_q}, {30'd0, IDLE});
    chk("rst done3", {31'd0, w3.done}, 32'd0);
    chk("rst valid3", {31'd0, r3.valid}, 32'd0);
    chk("rst flags3", {30'd0, oor3, proto3}, 32'd0);
    rst_n = 1'b1;

    // Latency 1 basic write/read, byte offset ignored.
    xact("wr10", 1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, '0, 1, 0, 0, '0);
    xact("rd10", 1, 1'b0, '0, 4'h0, '0, 1'b1, 32'h10, 0, 1, 0, '0);
    xact("rd13", 1, 1'b0, '0, 4'h0, '0, 1'b1, 32'h13, 0, 1, 0, '0);

    // Byte strobes and empty strobe.
    xact("wr40", 1, 1'b1, 32'h40, 4'hF, 32'h11223344, 1'b0, '0, 1, 0, 0, '0);
    xact("wr40b2", 1, 1'b1, 32'h40, 4'b0100, 32'h00AB0000, 1'b0, '0, 1, 0, 0, '0);
    xact("rd40", 1, 1'b0, '0, 4'h0, '0, 1'b1, 32'h40, 0, 1, 0, '0);
    xact("wr40s0", 1, 1'b1, 32'h40, 4'h0, 32'hFFFFFFFF, 1'b0, '0, 1, 0, 0, '0);
    xact("rd40s0", 1, 1'b0, '0, 4'h0, '0, 1'b1, 32'h40, 0, 1, 0, '0);

    // Out of range: 0x1000 would alias word 0 if the range check were missing.
    xact("wr0", 1, 1'b1, 32'h0, 4'hF, 32'h01020304, 1'b0, '0, 1, 0, 0, '0);
    chk("oor clear", {31'd0, oor1}, 32'd0);
    xact("rdoor", 1, 1'b0, '0, 4'h0, '0, 1'b1, 32'h1000, 0, 1, 0, '0);
    chk("oor after read", {31'd0, oor1}, 32'd1);
    xact("wroor", 1, 1'b1, 32'h1000, 4'hF, 32'hCAFEF00D, 1'b0, '0, 1, 0, 0, '0);
    xact("rd0", 1, 1'b0, '0, 4'h0, '0, 1'b1, 32'h0, 0, 1, 0, '0);
    chk("oor sticky", {31'd0, oor1}, 32'd1);
    chk("proto1 clear", {31'd0, proto1}, 32'd0);

    // Read 3 / write 2: simultaneous write+read serves write first, read sees new word.
    xact("wr20", 3, 1'b1, 32'h20, 4'hF, 32'h55555555, 1'b0, '0, 2, 0, 0, '0);
    xact("wrrd20", 3, 1'b1, 32'h20, 4'hF, 32'h0BADCAFE, 1'b1, 32'h20, 2, 5, 0, '0);
    chk("proto3 clear", {31'd0, proto3}, 32'd0);

    // Second avalid while busy is dropped.
    xact("wr30", 3, 1'b1, 32'h30, 4'hF, 32'hA5A5A5A5, 1'b0, '0, 2, 0, 0, '0);
    xact("proto", 3, 1'b0, '0, 4'h0, '0, 1'b1, 32'h20, 0, 3, 1, 32'h30);
    chk("proto3 set", {31'd0, proto3}, 32'd1);

    // Reset asserted during the write completion cycle; model is left untouched.
    @(negedge clk);
    drive(3, 1'b1, 32'h20, 4'hF, 32'h77777777, 1'b0, '0);
    @(posedge clk);
    #1 drive(3, 1'b0, '0, 4'h0, '0, 1'b0, '0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rstmid done", {31'd0, w3.done}, 32'd0);
    chk("rstmid valid", {31'd0, r3.valid}, 32'd0);
    chk("rstmid data", r3.data, 32'd0);
    @(negedge clk);
    chk("rstmid state", {30'd0, dut3.state_q}, {30'd0, IDLE});
    chk("rstmid flags3", {30'd0, oor3, proto3}, 32'd0);
    chk("rstmid oor1", {31'd0, oor1}, 32'd0);
    rst_n = 1'b1;
    xact("rd20 post rst", 3, 1'b0, '0, 4'h0, '0, 1'b1, 32'h20, 0, 3, 0, '0);
    chk("queue empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
